tile_scroll_ctrl: RTL

- Game-side sequencer directly upstream of the column draw controller.
- Owns the 6-row tile field (row 0 top, 40 px per row, lanes at x=120/140/160/180, 20 px wide). Scrolls the field by frame ticks and inserts pseudo-random tiles at the top.
- Judges key presses against the bottom row and keeps score.
- Issues draw_go for each updated frame and waits for the draw controller's done handshake. Its row codes, offsets and previous-frame copies feed the per-line draw/erase engines.

---
 rtl/tile_scroll_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tile_scroll_ctrl.sv
// Tile field sequencer: scrolls a 6-row lane field, judges key hits on the bottom row and
// handshakes each frame with the column draw controller. Optional macro TILE_SPEEDUP_EN.
module tile_scroll_ctrl #(
  parameter int         ROW_H     = 40,
  parameter int         SPEED     = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [3:0]  key_hit,
  input  logic        draw_done,
  output logic        draw_go,
  output logic [17:0] rows,
  output logic [17:0] prev_rows,
  output logic [5:0]  offset,
  output logic [5:0]  prev_offset,
  output logic [7:0]  score,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_WAIT, S_ADVANCE, S_DRAW_REQ, S_DRAW_REL, S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [17:0] rows_q, rows_d, prev_rows_q, prev_rows_d;
  logic [5:0]  off_q, off_d, prev_off_q, prev_off_d;
  logic [7:0]  score_q, score_d;
  logic        over_q, over_d;
  logic        go_q;
  logic [6:0]  step, sum;
  logic [1:0]  key_lane;
  logic        key_any, key_match;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

`ifdef TILE_SPEEDUP_EN
  logic [6:0] boost;
  // Every 8 hits adds a pixel per frame, capped so a shift never skips a row.
  always_comb begin
    boost = 7'(SPEED) + {2'b00, score_q[7:3]};
    step  = (boost > 7'(ROW_H - 1)) ? 7'(ROW_H - 1) : boost;
  end
`else
  assign step = 7'(SPEED);
`endif

  assign sum = {1'b0, off_q} + step;

  // Only the lowest pressed lane is judged.
  always_comb begin
    key_lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (key_hit[k]) key_lane = 2'(k);
    end
  end

  assign key_any   = |key_hit;
  assign key_match = (rows_q[17:15] != 3'd0) && (rows_q[17:15] == {1'b0, key_lane} + 3'd1);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_next(lfsr_q);
    rows_d      = rows_q;
    prev_rows_d = prev_rows_q;
    off_d       = off_q;
    prev_off_d  = prev_off_q;
    score_d     = score_q;
    over_d      = over_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          rows_d  = '0;
          off_d   = '0;
          score_d = '0;
          over_d  = 1'b0;
          lfsr_d  = LFSR_SEED;
          state_d = S_DRAW_REQ;
        end
      end
      S_RUN_WAIT: begin
        if (key_any && !key_match) begin
          over_d  = 1'b1;
          state_d = S_OVER;
        end else begin
          if (key_any) begin
            rows_d[17:15] = 3'd0;
            score_d       = sat_inc(score_q);
          end
          if (frame_tick) state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        prev_rows_d = rows_q;
        prev_off_d  = off_q;
        if (sum < 7'(ROW_H)) begin
          off_d = sum[5:0];
        end else begin
          off_d  = 6'(sum - 7'(ROW_H));
          rows_d = {rows_q[14:0], {1'b0, lfsr_q[1:0]} + 3'd1};
          if (rows_q[17:15] != 3'd0) over_d = 1'b1;
        end
        state_d = S_DRAW_REQ;
      end
      S_DRAW_REQ: if (draw_done) state_d = S_DRAW_REL;
      S_DRAW_REL: if (!draw_done) state_d = over_q ? S_OVER : S_RUN_WAIT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      rows_q      <= '0;
      prev_rows_q <= '0;
      off_q       <= '0;
      prev_off_q  <= '0;
      score_q     <= '0;
      over_q      <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      rows_q      <= rows_d;
      prev_rows_q <= prev_rows_d;
      off_q       <= off_d;
      prev_off_q  <= prev_off_d;
      score_q     <= score_d;
      over_q      <= over_d;
      go_q        <= (state_d == S_DRAW_REQ);
    end
  end

  assign draw_go     = go_q;
  assign rows        = rows_q;
  assign prev_rows   = prev_rows_q;
  assign offset      = off_q;
  assign prev_offset = prev_off_q;
  assign score       = score_q;
  assign game_over   = over_q;

endmodule
